gbuff_out_writer: RTL and testbench
===================================

// Module: gbuff_out_writer
// PURPOSE
//  Write-side engine for the output global buffer (GBUFF_OUT). Takes per-row
//  result beats from the systolic array (4 bytes = one 4-column tile), packs
//  them into 32-bit words and writes them at row*row_offset + tile. Raises done
//  once the full m x n result is in memory, so the bench can read GBUFF_OUT.
// PARAMETERS
//  DATA_SIZE  8   bits per result element
//  WORD_SIZE  32  GBUFF word width (4 elements)
//  ADDR_SIZE  8   GBUFF_OUT address width
// PORTS
//  clk       in   1          clock, all logic on rising edge
//  rst       in   1          synchronous reset, active-high
//  start     in   1          begin a job; sampled in IDLE/DONE only
//  m         in   4          result rows
//  n         in   4          result cols
//  in_valid  in   1          result beat valid
//  in_ready  out  1          writer accepts a beat (beat taken when valid&ready)
//  in_data   in   WORD_SIZE  element j of tile in [8j+7:8j], j=0..3
//  wr_en     out  1          GBUFF_OUT write strobe
//  wr_addr   out  ADDR_SIZE  GBUFF_OUT word address
//  wr_data   out  WORD_SIZE  GBUFF_OUT write data
//  done      out  1          job complete (level)
// BEHAVIOUR
//  Reset: state=IDLE; in_ready, wr_en, done = 0; wr_addr, wr_data = 0; counters = 0.
//  Reset takes priority over every other input; reset mid-job aborts the job
//   with no further writes. Memory contents already written are untouched.
//  row_offset (words per row) = n>=9 ? 3 : n>=5 ? 2 : 1. n in 13..15 -> 3.
//  States:
//   IDLE: in_ready=0. On start: latch m,n,row_offset; tile=0, row=0.
//    If m==0 or n==0 -> DONE (no writes); else -> RUN.
//   RUN: in_ready=1. Each accepted beat is registered; next cycle
//    wr_en=1, wr_addr=row*row_offset+tile, wr_data=in_data with element j
//    forced to 0 when 4*tile+j >= n (latency 1, one write per beat).
//    Order: row advances first (0..m-1), then tile (0..row_offset-1).
//    Accepting the last beat (row==m-1, tile==row_offset-1) -> FLUSH.
//   FLUSH: in_ready=0; last write appears on wr_en this cycle -> DONE.
//   DONE: done=1 held; in_ready=0; start -> same handling as in IDLE
//    (done drops the cycle after start is sampled).
//  wr_en is high only the cycle after an accepted beat; never in IDLE/DONE.
//  in_valid while in_ready=0 is ignored (beat not consumed, no write).
//  in_valid gaps in RUN: stall, counters hold, wr_en=0 that cycle.
//  start during RUN/FLUSH is ignored.
//  Counters are 4 bits (row) and 2 bits (tile); address math fits in
//   ADDR_SIZE for m<=15 (max addr 44).
// TESTING
//  1: m=4,n=4, 4 beats 0x04030201+r*0x04040404 -> writes addr 0..3,
//     wr_data matches beats, done=1 one cycle after last wr_en.
//  2: m=2,n=6, beats r0t0,r1t0,r0t1,r1t1 -> addr 0,2,1,3; t1 words have
//     bytes [31:16]=0.
//  3: m=3,n=12, continuous valid -> 9 writes, addr order 0,3,6,1,4,7,2,5,8,
//     no byte masking.
//  4: m=2,n=4, in_valid toggled 1,0,1 -> exactly 2 writes, none during gap.
//  5: m=0,n=5 start -> done=1 within 1 cycle, wr_en never asserted.
//  6: rst=1 after 2nd beat of m=4,n=4 -> next cycle state IDLE, outputs 0,
//     no writes; restart with m=1,n=1 -> one write addr 0, data
//     0x000000AA for beat 0x332211AA, then done=1.

Source files
------------

// File: rtl/gbuff_out_writer_if.sv
`default_nettype none
// ============================================================================
//  Module   : gbuff_out_writer_if
//  Purpose  : Result-beat handshake plus GBUFF_OUT write port bundle.
//  Revision : 1.0 - initial release
// ============================================================================
interface gbuff_out_writer_if #(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_SIZE = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WORD_SIZE-1:0] in_data;
    logic                 wr_en;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [WORD_SIZE-1:0] wr_data;

    // Producer of result beats / consumer of the memory writes
    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    // The writer engine
    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface
`default_nettype wire

// File: rtl/gbuff_out_writer.sv
`default_nettype none
// ============================================================================
//  Module   : gbuff_out_writer
//  Purpose  : Packs systolic-array result tiles into GBUFF_OUT words and
//             writes them at row*row_offset + tile; flags done when complete.
//  Revision : 1.0 - initial release
// ============================================================================
module gbuff_out_writer #(
    parameter int DATA_SIZE = 8,
    parameter int WORD_SIZE = 32,
    parameter int ADDR_SIZE = 8
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       start,
    input  wire logic [3:0] m,
    input  wire logic [3:0] n,
    output logic            done,
    gbuff_out_writer_if.slave bus
);

    localparam int C_NELEM = WORD_SIZE / DATA_SIZE;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [3:0]           r_m, w_m_nxt;
    logic [3:0]           r_n, w_n_nxt;
    logic [1:0]           r_row_off, w_row_off_nxt;
    logic [3:0]           r_row, w_row_nxt;
    logic [1:0]           r_tile, w_tile_nxt;
    logic                 r_wr_en, w_wr_en_nxt;
    logic [ADDR_SIZE-1:0] r_wr_addr, w_wr_addr_nxt;
    logic [WORD_SIZE-1:0] r_wr_data, w_wr_data_nxt;

    logic [1:0]           w_row_off_in;
    logic [ADDR_SIZE-1:0] w_addr;
    logic [WORD_SIZE-1:0] w_masked;

    // Columns 13..15 have no fourth tile slot; they share the three-word layout
    assign w_row_off_in = (n >= 4'd9) ? 2'd3 : (n >= 4'd5) ? 2'd2 : 2'd1;

    assign w_addr = ADDR_SIZE'(r_row) * ADDR_SIZE'(r_row_off) + ADDR_SIZE'(r_tile);

    // Zero the elements of the current tile that lie beyond column n-1
    genvar gj;
    generate
        for (gj = 0; gj < C_NELEM; gj++) begin : g_mask
            logic [5:0] w_col;
            assign w_col = {2'b00, r_tile, 2'b00} + 6'(gj);
            assign w_masked[gj*DATA_SIZE +: DATA_SIZE] =
                (w_col >= {2'b00, r_n}) ? '0 : bus.in_data[gj*DATA_SIZE +: DATA_SIZE];
        end
    endgenerate

    assign bus.in_ready = (r_state == S_RUN);
    assign bus.wr_en    = r_wr_en;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
    assign done         = (r_state == S_DONE);

    always_comb begin
        w_state_nxt   = r_state;
        w_m_nxt       = r_m;
        w_n_nxt       = r_n;
        w_row_off_nxt = r_row_off;
        w_row_nxt     = r_row;
        w_tile_nxt    = r_tile;
        w_wr_en_nxt   = 1'b0;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_m_nxt       = m;
                    w_n_nxt       = n;
                    w_row_off_nxt = w_row_off_in;
                    w_row_nxt     = 4'd0;
                    w_tile_nxt    = 2'd0;
                    w_state_nxt   = (m == 4'd0 || n == 4'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (bus.in_valid) begin
                    w_wr_en_nxt   = 1'b1;
                    w_wr_addr_nxt = w_addr;
                    w_wr_data_nxt = w_masked;
                    // Walk down the rows of a tile column before moving right
                    if (r_row == r_m - 4'd1) begin
                        w_row_nxt = 4'd0;
                        if (r_tile == r_row_off - 2'd1) begin
                            w_state_nxt = S_FLUSH;
                        end else begin
                            w_tile_nxt = r_tile + 2'd1;
                        end
                    end else begin
                        w_row_nxt = r_row + 4'd1;
                    end
                end
            end
            S_FLUSH: begin
                w_state_nxt = S_DONE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_m       <= 4'd0;
            r_n       <= 4'd0;
            r_row_off <= 2'd0;
            r_row     <= 4'd0;
            r_tile    <= 2'd0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_m       <= w_m_nxt;
            r_n       <= w_n_nxt;
            r_row_off <= w_row_off_nxt;
            r_row     <= w_row_nxt;
            r_tile    <= w_tile_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gbuff_out_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gbuff_out_writer
//  Purpose  : Directed, table-driven self-checking bench for gbuff_out_writer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gbuff_out_writer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] m;
    logic [3:0] n;
    logic       done;

    gbuff_out_writer_if #(.WORD_SIZE(32), .ADDR_SIZE(8)) bus ();

    gbuff_out_writer #(
        .DATA_SIZE(8),
        .WORD_SIZE(32),
        .ADDR_SIZE(8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .m     (m),
        .n     (n),
        .done  (done),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          vm;
        int          vn;
        bit          first;
        logic [31:0] din;
        logic [7:0]  eaddr;
        logic [31:0] edata;
    } vec_t;

    vec_t tbl[32];
    int   nv;
    int   errors;
    int   checks;
    int   wr_count;
    int   c0;
    bit   last;

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) wr_count++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input int vm, input int vn, input bit first,
                       input logic [31:0] din, input logic [7:0] ea, input logic [31:0] ed);
        tbl[nv].vm    = vm;
        tbl[nv].vn    = vn;
        tbl[nv].first = first;
        tbl[nv].din   = din;
        tbl[nv].eaddr = ea;
        tbl[nv].edata = ed;
        nv++;
    endtask

    // Called at a negedge; returns at the following negedge with the job running
    task automatic start_job(input int vm, input int vn);
        start = 1'b1;
        m     = 4'(vm);
        n     = 4'(vn);
        @(posedge clk); #1;
        chk("done_drops_on_start", {31'd0, done}, 32'd0);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        wr_count = 0;
        nv       = 0;
        rst      = 1'b1;
        start    = 1'b0;
        m        = 4'd0;
        n        = 4'd0;
        bus.in_valid = 1'b0;
        bus.in_data  = 32'd0;

        // m=4,n=4: one word per row, no masking
        add(4, 4, 1, 32'h04030201, 8'd0, 32'h04030201);
        add(4, 4, 0, 32'h08070605, 8'd1, 32'h08070605);
        add(4, 4, 0, 32'h0C0B0A09, 8'd2, 32'h0C0B0A09);
        add(4, 4, 0, 32'h100F0E0D, 8'd3, 32'h100F0E0D);
        // m=2,n=6: two words per row, upper half of tile 1 zeroed
        add(2, 6, 1, 32'h11111111, 8'd0, 32'h11111111);
        add(2, 6, 0, 32'h22222222, 8'd2, 32'h22222222);
        add(2, 6, 0, 32'h33333333, 8'd1, 32'h00003333);
        add(2, 6, 0, 32'h44444444, 8'd3, 32'h00004444);
        // m=3,n=12: three words per row, full tiles
        add(3, 12, 1, 32'h30000000, 8'd0, 32'h30000000);
        add(3, 12, 0, 32'h30000001, 8'd3, 32'h30000001);
        add(3, 12, 0, 32'h30000002, 8'd6, 32'h30000002);
        add(3, 12, 0, 32'h30000003, 8'd1, 32'h30000003);
        add(3, 12, 0, 32'h30000004, 8'd4, 32'h30000004);
        add(3, 12, 0, 32'h30000005, 8'd7, 32'h30000005);
        add(3, 12, 0, 32'h30000006, 8'd2, 32'h30000006);
        add(3, 12, 0, 32'h30000007, 8'd5, 32'h30000007);
        add(3, 12, 0, 32'h30000008, 8'd8, 32'h30000008);
        // n=5 boundary: second tile keeps only element 4
        add(1, 5, 1, 32'h55667788, 8'd0, 32'h55667788);
        add(1, 5, 0, 32'h99AABBCC, 8'd1, 32'h000000CC);
        // n=9 boundary: third tile keeps only element 8
        add(1, 9, 1, 32'hDEADBEEF, 8'd0, 32'hDEADBEEF);
        add(1, 9, 0, 32'hCAFEF00D, 8'd1, 32'hCAFEF00D);
        add(1, 9, 0, 32'h12345678, 8'd2, 32'h00000078);
        // n=14: still three words per row, tile 2 complete
        add(1, 14, 1, 32'hA1A2A3A4, 8'd0, 32'hA1A2A3A4);
        add(1, 14, 0, 32'hB1B2B3B4, 8'd1, 32'hB1B2B3B4);
        add(1, 14, 0, 32'hC1C2C3C4, 8'd2, 32'hC1C2C3C4);

        // ---- reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready",   {31'd0, bus.in_ready}, 32'd0);
        chk("rst_wr_en",   {31'd0, bus.wr_en},    32'd0);
        chk("rst_wr_addr", {24'd0, bus.wr_addr},  32'd0);
        chk("rst_wr_data", bus.wr_data,           32'd0);
        chk("rst_done",    {31'd0, done},         32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ---- m=0: straight to done, no writes
        c0    = wr_count;
        start = 1'b1;
        m     = 4'd0;
        n     = 4'd5;
        @(posedge clk); #1;
        chk("m0_done",  {31'd0, done},         32'd1);
        chk("m0_wr_en", {31'd0, bus.wr_en},    32'd0);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("m0_done_held", {31'd0, done}, 32'd1);
        chk("m0_no_writes", 32'(wr_count - c0), 32'd0);

        // ---- table-driven jobs with continuous valid
        for (int i = 0; i < nv; i++) begin
            if (tbl[i].first) start_job(tbl[i].vm, tbl[i].vn);
            chk("run_ready", {31'd0, bus.in_ready}, 32'd1);
            bus.in_valid = 1'b1;
            bus.in_data  = tbl[i].din;
            @(posedge clk); #1;
            chk("vec_wr_en",   {31'd0, bus.wr_en},   32'd1);
            chk("vec_wr_addr", {24'd0, bus.wr_addr}, {24'd0, tbl[i].eaddr});
            chk("vec_wr_data", bus.wr_data,          tbl[i].edata);
            last = (i == nv - 1);
            if (!last) last = tbl[i + 1].first;
            @(negedge clk);
            if (last) begin
                bus.in_valid = 1'b0;
                chk("flush_ready", {31'd0, bus.in_ready}, 32'd0);
                chk("flush_done",  {31'd0, done},         32'd0);
                @(posedge clk); #1;
                chk("job_done",       {31'd0, done},      32'd1);
                chk("job_done_wr_en", {31'd0, bus.wr_en}, 32'd0);
                @(negedge clk);
            end
        end

        // ---- valid while in DONE is ignored
        c0 = wr_count;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hFFFFFFFF;
        repeat (2) @(negedge clk);
        bus.in_valid = 1'b0;
        chk("done_ignores_valid", 32'(wr_count - c0), 32'd0);

        // ---- m=2,n=4 with a one-cycle valid gap
        start_job(2, 4);
        c0 = wr_count;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hAAAA0001;
        @(posedge clk); #1;
        chk("gap_w0_addr", {24'd0, bus.wr_addr}, 32'd0);
        chk("gap_w0_data", bus.wr_data,          32'hAAAA0001);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("gap_no_write", {31'd0, bus.wr_en}, 32'd0);
        @(negedge clk);
        chk("gap_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hBBBB0002;
        @(posedge clk); #1;
        chk("gap_w1_addr", {24'd0, bus.wr_addr}, 32'd1);
        chk("gap_w1_data", bus.wr_data,          32'hBBBB0002);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("gap_done",   {31'd0, done},          32'd1);
        chk("gap_writes", 32'(wr_count - c0),     32'd2);
        @(negedge clk);

        // ---- reset mid-job aborts without further writes
        start_job(4, 4);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h01010101;
        @(posedge clk);
        @(negedge clk);
        bus.in_data  = 32'h02020202;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_wr_en",   {31'd0, bus.wr_en},    32'd0);
        chk("abort_ready",   {31'd0, bus.in_ready}, 32'd0);
        chk("abort_done",    {31'd0, done},         32'd0);
        chk("abort_wr_addr", {24'd0, bus.wr_addr},  32'd0);
        chk("abort_wr_data", bus.wr_data,           32'd0);
        @(negedge clk);
        rst = 1'b0;
        c0  = wr_count;
        bus.in_valid = 1'b1;
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b0;
        chk("abort_idle_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("abort_no_writes",  32'(wr_count - c0),    32'd0);

        // ---- restart m=1,n=1: only element 0 survives
        start_job(1, 1);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h332211AA;
        @(posedge clk); #1;
        chk("restart_wr_en",   {31'd0, bus.wr_en},   32'd1);
        chk("restart_wr_addr", {24'd0, bus.wr_addr}, 32'd0);
        chk("restart_wr_data", bus.wr_data,          32'h000000AA);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("restart_done", {31'd0, done}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
